mul_serial_mac: RTL and testbench

Bit-serial multiply-accumulate unit for the binary-serial PE array. It scans the multiplier operand one bit per cycle with an internal counter and adds a selected, shifted, sign-handled partial product per cycle. After WIDTH cycles it folds the complete product into a wide accumulator. It adds four things a plain per-bit partial-product selector lacks: a valid/ready input handshake, signed/unsigned mode, accumulator clear/abort control, and overflow flagging.

---
 rtl/mul_serial_pkg.sv | 20 ++
 rtl/mul_serial_mac_if.sv | 37 +++
 rtl/mul_serial_pp.sv | 34 +++
 rtl/mul_serial_mac.sv | 152 +++++++++++++++
 tb/tb_mul_serial_mac.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial_pkg
// Description : Shared types and default sizes for the bit-serial MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_serial_pkg;

   // FSM states of the serial multiplier
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int C_DEF_WIDTH = 8;
   localparam int C_DEF_ACCW  = 24;
   localparam int C_DEF_CNTW  = $clog2(C_DEF_WIDTH);

endpackage : mul_serial_pkg
`default_nettype wire

// File: rtl/mul_serial_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial_mac_if
// Description : Operand handshake and result bus of the bit-serial MAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_serial_mac_if
   import mul_serial_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int ACCW  = C_DEF_ACCW
);
   logic                 i_valid;
   logic                 o_ready;
   logic [WIDTH-1:0]     i_data0;
   logic [WIDTH-1:0]     i_data1;
   logic                 i_signed;
   logic                 i_acc_clr;
   logic                 i_abort;
   logic                 o_valid;
   logic [2*WIDTH-1:0]   o_prod;
   logic [ACCW-1:0]      o_acc;
   logic                 o_ovf;

   // Requester side: offers operands, observes results
   modport master (
      output i_valid, i_data0, i_data1, i_signed, i_acc_clr, i_abort,
      input  o_ready, o_valid, o_prod, o_acc, o_ovf
   );

   // MAC side
   modport slave (
      input  i_valid, i_data0, i_data1, i_signed, i_acc_clr, i_abort,
      output o_ready, o_valid, o_prod, o_acc, o_ovf
   );
endinterface : mul_serial_mac_if
`default_nettype wire

// File: rtl/mul_serial_pp.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial_pp
// Description : Combinational partial-product generator for one multiplier
//               bit: selects, extends, shifts and (signed MSB) negates op1.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_serial_pp
   import mul_serial_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  wire logic                        i_op0_bit,
   input  wire logic [WIDTH-1:0]            i_op1,
   input  wire logic [CW-1:0]               i_k,
   input  wire logic                        i_signed,
   output logic signed [2*WIDTH-1:0]        o_pp
);
   logic [2*WIDTH-1:0] w_ext;
   logic [2*WIDTH-1:0] w_sh;

   // Extend op1, gate by the scanned bit, shift into position, negate the MSB term when signed
   always_comb begin
      w_ext = i_signed ? {{WIDTH{i_op1[WIDTH-1]}}, i_op1} : {{WIDTH{1'b0}}, i_op1};
      w_sh  = i_op0_bit ? (w_ext << i_k) : '0;
      if (i_signed && (i_k == CW'(WIDTH-1))) begin
         o_pp = $signed(-w_sh);
      end else begin
         o_pp = $signed(w_sh);
      end
   end
endmodule : mul_serial_pp
`default_nettype wire

// File: rtl/mul_serial_mac.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial_mac
// Description : Bit-serial multiply-accumulate with valid/ready accept,
//               signed/unsigned mode, clear/abort control and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_serial_mac
   import mul_serial_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int ACCW  = C_DEF_ACCW
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   mul_serial_mac_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [WIDTH-1:0]       r_op0;
   logic [WIDTH-1:0]       r_op1;
   logic                   r_sgn;
   logic                   r_clr;
   logic [PW-1:0]          r_prod;
   logic [PW-1:0]          r_oprod;
   logic [ACCW-1:0]        r_acc;
   logic                   r_valid;
   logic                   r_ovf;

   logic                   w_accept;
   logic                   w_last;
   logic signed [PW-1:0]   w_pp;
   logic [PW-1:0]          w_final;
   logic [ACCW-1:0]        w_pext;
   logic [ACCW-1:0]        w_base;
   logic [ACCW:0]          w_sum;
   logic                   w_ovf;

   mul_serial_pp #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_pp (
      .i_op0_bit (r_op0[r_cnt]),
      .i_op1     (r_op1),
      .i_k       (r_cnt),
      .i_signed  (r_sgn),
      .o_pp      (w_pp)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: abort beats both accept and completion
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_valid && !bus.i_abort) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (bus.i_abort) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CW'(WIDTH-1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Running product including this cycle's term, and the accumulate that folds it in
   always_comb begin
      w_final = r_prod + $unsigned(w_pp);
      w_base  = r_clr ? '0 : r_acc;
      w_sum   = {1'b0, w_base} + {1'b0, w_pext};
      if (r_sgn) begin
         w_ovf = (w_base[ACCW-1] == w_pext[ACCW-1]) && (w_sum[ACCW-1] != w_base[ACCW-1]);
      end else begin
         w_ovf = w_sum[ACCW];
      end
   end

   generate
      if (ACCW > PW) begin : g_ext_wide
         assign w_pext = r_sgn ? {{(ACCW-PW){w_final[PW-1]}}, w_final}
                               : {{(ACCW-PW){1'b0}}, w_final};
      end else begin : g_ext_equal
         assign w_pext = w_final;
      end
   endgenerate

   // Operand latch at accept, serial product update during RUN, result fold on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_op0   <= '0;
         r_op1   <= '0;
         r_sgn   <= 1'b0;
         r_clr   <= 1'b0;
         r_prod  <= '0;
         r_oprod <= '0;
         r_acc   <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_op0  <= bus.i_data0;
            r_op1  <= bus.i_data1;
            r_sgn  <= bus.i_signed;
            r_clr  <= bus.i_acc_clr;
            r_prod <= '0;
            r_cnt  <= '0;
            if (bus.i_acc_clr) begin
               r_ovf <= 1'b0;
            end
         end else if ((r_state == RUN) && !bus.i_abort) begin
            r_prod <= w_final;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_oprod <= w_final;
               r_acc   <= w_sum[ACCW-1:0];
               r_valid <= 1'b1;
               r_ovf   <= r_ovf | w_ovf;
            end
         end
      end
   end

   assign bus.o_ready = (r_state == IDLE);
   assign bus.o_valid = r_valid;
   assign bus.o_prod  = r_oprod;
   assign bus.o_acc   = r_acc;
   assign bus.o_ovf   = r_ovf;
endmodule : mul_serial_mac
`default_nettype wire

// File: tb/tb_mul_serial_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_serial_mac
// Description : Directed self-checking bench for mul_serial_mac (WIDTH=8,
//               ACCW=24) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_serial_mac;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   lat;
   int   run_sum;
   logic [7:0] bb_a [4];
   logic [7:0] bb_b [4];

   mul_serial_mac_if #(.WIDTH(8), .ACCW(24)) u_if ();

   mul_serial_mac #(.WIDTH(8), .ACCW(24)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one operand pair, then wait (bounded) for the result pulse
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic clr, output int l);
      @(negedge clk);
      u_if.i_valid   = 1'b1;
      u_if.i_data0   = a;
      u_if.i_data1   = b;
      u_if.i_signed  = sgn;
      u_if.i_acc_clr = clr;
      @(posedge clk);
      #1;
      u_if.i_valid = 1'b0;
      l = 0;
      while (l < 20) begin
         @(posedge clk);
         #1;
         l++;
         if (u_if.o_valid) break;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      u_if.i_valid   = 1'b0;
      u_if.i_data0   = '0;
      u_if.i_data1   = '0;
      u_if.i_signed  = 1'b0;
      u_if.i_acc_clr = 1'b0;
      u_if.i_abort   = 1'b0;
      bb_a[0] = 8'd10;  bb_b[0] = 8'd20;
      bb_a[1] = 8'd3;   bb_b[1] = 8'd7;
      bb_a[2] = 8'd100; bb_b[2] = 8'd2;
      bb_a[3] = 8'd255; bb_b[3] = 8'd1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(u_if.o_ready), 64'd1);
      chk("rst_valid", 64'(u_if.o_valid), 64'd0);
      chk("rst_prod",  64'(u_if.o_prod),  64'd0);
      chk("rst_acc",   64'(u_if.o_acc),   64'd0);
      chk("rst_ovf",   64'(u_if.o_ovf),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: signed 3 x -5
      do_op(8'd3, 8'hFB, 1'b1, 1'b1, lat);
      chk("t1_latency", 64'(lat), 64'd8);
      chk("t1_prod", 64'(u_if.o_prod), 64'h0000FFF1);
      chk("t1_acc",  64'(u_if.o_acc),  64'h00FFFFF1);
      chk("t1_ready_with_valid", 64'(u_if.o_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("t1_valid_one_cycle", 64'(u_if.o_valid), 64'd0);
      chk("t1_prod_hold", 64'(u_if.o_prod), 64'h0000FFF1);

      // 2: signed extremes
      do_op(8'h80, 8'h80, 1'b1, 1'b1, lat);
      chk("t2_prod", 64'(u_if.o_prod), 64'd16384);
      chk("t2_acc",  64'(u_if.o_acc),  64'd16384);
      chk("t2_ovf",  64'(u_if.o_ovf),  64'd0);
      do_op(8'h80, 8'h7F, 1'b1, 1'b0, lat);
      chk("t2b_prod", 64'(u_if.o_prod), 64'h0000C080);
      chk("t2b_acc",  64'(u_if.o_acc),  64'd128);
      chk("t2b_ovf",  64'(u_if.o_ovf),  64'd0);

      // Signed accumulation overflow: 512 x 16384 = 2^23 crosses the positive limit
      do_op(8'h80, 8'h80, 1'b1, 1'b1, lat);
      for (int i = 1; i < 511; i++) do_op(8'h80, 8'h80, 1'b1, 1'b0, lat);
      chk("sovf_acc_before", 64'(u_if.o_acc), 64'h007FC000);
      chk("sovf_ovf_before", 64'(u_if.o_ovf), 64'd0);
      do_op(8'h80, 8'h80, 1'b1, 1'b0, lat);
      chk("sovf_acc", 64'(u_if.o_acc), 64'h00800000);
      chk("sovf_ovf", 64'(u_if.o_ovf), 64'd1);

      // 3: unsigned extreme, accumulation wrap
      do_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat);
      chk("t3_prod", 64'(u_if.o_prod), 64'd65025);
      chk("t3_acc",  64'(u_if.o_acc),  64'd65025);
      chk("t3_ovf_cleared", 64'(u_if.o_ovf), 64'd0);
      for (int i = 0; i < 257; i++) do_op(8'hFF, 8'hFF, 1'b0, 1'b0, lat);
      chk("t3_acc_258", 64'(u_if.o_acc), 64'd16776450);
      chk("t3_ovf_258", 64'(u_if.o_ovf), 64'd0);
      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, lat);
      chk("t3_acc_wrap", 64'(u_if.o_acc), 64'd64259);
      chk("t3_ovf_set",  64'(u_if.o_ovf), 64'd1);
      @(negedge clk);
      u_if.i_valid   = 1'b1;
      u_if.i_data0   = 8'd2;
      u_if.i_data1   = 8'd3;
      u_if.i_signed  = 1'b0;
      u_if.i_acc_clr = 1'b1;
      @(posedge clk);
      #1;
      u_if.i_valid = 1'b0;
      chk("t3_ovf_clr_at_accept", 64'(u_if.o_ovf), 64'd0);
      chk("t3_busy", 64'(u_if.o_ready), 64'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("t3_clr_acc", 64'(u_if.o_acc), 64'd6);

      // Abort in IDLE has priority over accept
      @(negedge clk);
      u_if.i_valid = 1'b1;
      u_if.i_abort = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_abort_no_accept", 64'(u_if.o_ready), 64'd1);
      @(negedge clk);
      u_if.i_valid = 1'b0;
      u_if.i_abort = 1'b0;

      // 4: abort at k=4
      @(negedge clk);
      u_if.i_valid   = 1'b1;
      u_if.i_data0   = 8'd7;
      u_if.i_data1   = 8'd9;
      u_if.i_acc_clr = 1'b0;
      @(posedge clk);
      #1;
      u_if.i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t4_acc_stable_in_run", 64'(u_if.o_acc), 64'd6);
      @(negedge clk);
      u_if.i_abort = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_ready_after_abort", 64'(u_if.o_ready), 64'd1);
      @(negedge clk);
      u_if.i_abort = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (u_if.o_valid) lat++;
      end
      chk("t4_no_valid", 64'(lat), 64'd0);
      chk("t4_acc", 64'(u_if.o_acc), 64'd6);
      chk("t4_prod", 64'(u_if.o_prod), 64'd6);
      do_op(8'd5, 8'd5, 1'b0, 1'b0, lat);
      chk("t4_next_latency", 64'(lat), 64'd8);
      chk("t4_next_prod", 64'(u_if.o_prod), 64'd25);
      chk("t4_next_acc", 64'(u_if.o_acc), 64'd31);

      // Abort coinciding with the last RUN cycle
      @(negedge clk);
      u_if.i_valid = 1'b1;
      u_if.i_data0 = 8'd4;
      u_if.i_data1 = 8'd4;
      @(posedge clk);
      #1;
      u_if.i_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      u_if.i_abort = 1'b1;
      @(posedge clk);
      #1;
      chk("last_abort_valid", 64'(u_if.o_valid), 64'd0);
      chk("last_abort_ready", 64'(u_if.o_ready), 64'd1);
      @(negedge clk);
      u_if.i_abort = 1'b0;
      @(posedge clk);
      #1;
      chk("last_abort_valid2", 64'(u_if.o_valid), 64'd0);
      chk("last_abort_acc", 64'(u_if.o_acc), 64'd31);

      // 5: back-to-back with i_valid held high
      run_sum = 0;
      @(negedge clk);
      u_if.i_valid  = 1'b1;
      u_if.i_signed = 1'b0;
      for (int i = 0; i < 4; i++) begin
         u_if.i_data0   = bb_a[i];
         u_if.i_data1   = bb_b[i];
         u_if.i_acc_clr = (i == 0);
         @(posedge clk);
         #1;
         chk("b2b_accepted", 64'(u_if.o_ready), 64'd0);
         lat = 0;
         while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (u_if.o_valid) break;
         end
         run_sum += int'(bb_a[i]) * int'(bb_b[i]);
         chk("b2b_latency", 64'(lat), 64'd8);
         chk("b2b_ready_with_valid", 64'(u_if.o_ready), 64'd1);
         chk("b2b_acc", 64'(u_if.o_acc), 64'(run_sum));
         @(negedge clk);
      end
      u_if.i_valid   = 1'b0;
      u_if.i_acc_clr = 1'b0;
      chk("b2b_final_sum", 64'(u_if.o_acc), 64'd676);

      // 6: reset at k=3
      @(negedge clk);
      u_if.i_valid = 1'b1;
      u_if.i_data0 = 8'd9;
      u_if.i_data1 = 8'd9;
      @(posedge clk);
      #1;
      u_if.i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_ready", 64'(u_if.o_ready), 64'd1);
      chk("t6_valid", 64'(u_if.o_valid), 64'd0);
      chk("t6_prod",  64'(u_if.o_prod),  64'd0);
      chk("t6_acc",   64'(u_if.o_acc),   64'd0);
      chk("t6_ovf",   64'(u_if.o_ovf),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_ready_after_release", 64'(u_if.o_ready), 64'd1);
      do_op(8'd2, 8'd3, 1'b0, 1'b0, lat);
      chk("t6_post_reset_acc", 64'(u_if.o_acc), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule : tb_mul_serial_mac
`default_nettype wire
